// File: rtl/reg_operand_pkg.sv
// Shared constants and types for the register operand unit and the
// rs1/rs2 agents that drive its read-address ports.
package reg_operand_pkg;

  localparam int DEF_XLEN         = 32;
  localparam int DEF_NUM_REGS     = 32;
  localparam int DEF_NUM_RD_PORTS = 2;
  localparam int REG_ADDR_W       = $clog2(DEF_NUM_REGS);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_XLEN-1:0]   reg_data_t;

endpackage

// File: rtl/reg_busy_scoreboard.sv
// Per-register busy (pending write) vector with a registered popcount.
// x0 is never busy.
module reg_busy_scoreboard
  import reg_operand_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int CNT_W    = $clog2(NUM_REGS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                reserve_en,
  input  logic [ADDR_W-1:0]   reserve_addr,
  input  logic                wb_en,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_q,
  output logic [CNT_W-1:0]    busy_count
);

  logic [NUM_REGS-1:0] busy_d;
  logic [CNT_W-1:0]    count_d;

  // Next busy state: reserve beats flush, flush beats writeback, else hold.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (reserve_en && (reserve_addr == ADDR_W'(r)))
        busy_d[r] = 1'b1;
      else if (flush)
        busy_d[r] = 1'b0;
      else if (wb_en && (wb_addr == ADDR_W'(r)))
        busy_d[r] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  // Popcount of the post-update vector so the registered count tracks busy_q.
  always_comb begin
    count_d = '0;
    for (int r = 0; r < NUM_REGS; r++)
      count_d = count_d + CNT_W'(busy_d[r]);
  end

  // Busy vector and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      busy_count <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_count <= count_d;
    end
  end

endmodule

// File: rtl/reg_operand_unit.sv
// N-read/1-write register file combined with a busy scoreboard. Each read
// port returns operand data plus a hazard flag, one cycle after the request.
//
// Read protocol: rd_en_i[p] is a request with no back-pressure. A request
// sampled at edge k produces rd_valid_o[p]=1 during cycle k+1; rd_data_o and
// rd_busy_o for that port then hold until the port's next request.
module reg_operand_unit
  import reg_operand_pkg::*;
#(
  parameter  int XLEN         = DEF_XLEN,
  parameter  int NUM_REGS     = DEF_NUM_REGS,
  parameter  int NUM_RD_PORTS = DEF_NUM_RD_PORTS,
  localparam int ADDR_W       = $clog2(NUM_REGS),
  localparam int CNT_W        = $clog2(NUM_REGS + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_RD_PORTS-1:0]        rd_en_i,
  input  logic [NUM_RD_PORTS*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD_PORTS*XLEN-1:0]   rd_data_o,
  output logic [NUM_RD_PORTS-1:0]        rd_busy_o,
  output logic [NUM_RD_PORTS-1:0]        rd_valid_o,
  input  logic                           reserve_en_i,
  input  logic [ADDR_W-1:0]              reserve_addr_i,
  input  logic                           wb_en_i,
  input  logic [ADDR_W-1:0]              wb_addr_i,
  input  logic [XLEN-1:0]                wb_data_i,
  input  logic                           flush_i,
  output logic [CNT_W-1:0]               busy_count_o
);

  logic [XLEN-1:0]     regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy_vec;
  logic                wb_live;

  // Writes to x0 are dropped so x0 storage stays zero.
  assign wb_live = wb_en_i && (wb_addr_i != '0);

  reg_busy_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .CNT_W    (CNT_W)
  ) u_busy (
    .clk          (clk),
    .rst_n        (rst_n),
    .reserve_en   (reserve_en_i),
    .reserve_addr (reserve_addr_i),
    .wb_en        (wb_en_i),
    .wb_addr      (wb_addr_i),
    .flush        (flush_i),
    .busy_q       (busy_vec),
    .busy_count   (busy_count_o)
  );

  // Register storage, written by the writeback port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++)
        regs[r] <= '0;
    end else if (wb_live) begin
      regs[wb_addr_i] <= wb_data_i;
    end
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    logic [ADDR_W-1:0] addr;
    logic              bypass;
    logic [XLEN-1:0]   data_next;
    logic              busy_next;
    logic [XLEN-1:0]   data_q;
    logic              busy_q;
    logic              valid_q;

    assign addr   = rd_addr_i[p*ADDR_W +: ADDR_W];
    assign bypass = wb_live && (wb_addr_i == addr);

    // Operand select: x0 reads zero, a same-cycle writeback forwards, and a
    // same-cycle writeback also retires the hazard. Same-cycle reserves are
    // from younger instructions and are deliberately not seen here.
    always_comb begin
      data_next = '0;
      busy_next = 1'b0;
      if (addr != '0) begin
        data_next = bypass ? wb_data_i : regs[addr];
        busy_next = busy_vec[addr] && !bypass;
      end
    end

    // One-cycle read pipeline; data/busy hold between requests.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q  <= '0;
        busy_q  <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_en_i[p];
        if (rd_en_i[p]) begin
          data_q <= data_next;
          busy_q <= busy_next;
        end
      end
    end

    assign rd_data_o[p*XLEN +: XLEN] = data_q;
    assign rd_busy_o[p]              = busy_q;
    assign rd_valid_o[p]             = valid_q;
  end

endmodule

// File: tb/tb_reg_operand_unit.sv
// Directed bench for reg_operand_unit with hand-computed expectations.
module tb_reg_operand_unit;
  import reg_operand_pkg::*;

  localparam int XLEN   = DEF_XLEN;
  localparam int NP     = DEF_NUM_RD_PORTS;
  localparam int ADDR_W = REG_ADDR_W;
  localparam int CNT_W  = $clog2(DEF_NUM_REGS + 1);

  logic                   clk;
  logic                   rst_n;
  logic [NP-1:0]          rd_en;
  logic [NP*ADDR_W-1:0]   rd_addr;
  logic [NP*XLEN-1:0]     rd_data;
  logic [NP-1:0]          rd_busy;
  logic [NP-1:0]          rd_valid;
  logic                   reserve_en;
  logic [ADDR_W-1:0]      reserve_addr;
  logic                   wb_en;
  logic [ADDR_W-1:0]      wb_addr;
  logic [XLEN-1:0]        wb_data;
  logic                   flush;
  logic [CNT_W-1:0]       busy_count;

  int n_checks = 0;
  int n_fail   = 0;

  reg_operand_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rd_en_i        (rd_en),
    .rd_addr_i      (rd_addr),
    .rd_data_o      (rd_data),
    .rd_busy_o      (rd_busy),
    .rd_valid_o     (rd_valid),
    .reserve_en_i   (reserve_en),
    .reserve_addr_i (reserve_addr),
    .wb_en_i        (wb_en),
    .wb_addr_i      (wb_addr),
    .wb_data_i      (wb_data),
    .flush_i        (flush),
    .busy_count_o   (busy_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = '0; reserve_en = 1'b0; wb_en = 1'b0; flush = 1'b0;
  endtask

  task automatic drive_read(input int p, input logic [ADDR_W-1:0] a);
    rd_en[p] = 1'b1;
    rd_addr[p*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic drive_wb(input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
  endtask

  task automatic drive_reserve(input logic [ADDR_W-1:0] a);
    reserve_en = 1'b1; reserve_addr = a;
  endtask

  // Tests
  task automatic test_reset();
    idle(); rd_addr = '0; reserve_addr = '0; wb_addr = '0; wb_data = '0;
    rst_n = 1'b0;
    tick(); tick();
    n_checks++; if (rd_valid !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b expected 00", rd_valid); end
    n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", rd_data); end
    n_checks++; if (busy_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", busy_count); end
    rst_n = 1'b1;
    tick();
    n_checks++; if (rd_valid !== 2'b00) begin n_fail++; $display("FAIL post_release_valid: got %b expected 00", rd_valid); end
    drive_read(0, 5); drive_read(1, 0);
    tick(); idle();
    n_checks++; if (rd_valid !== 2'b11) begin n_fail++; $display("FAIL first_read_valid: got %b expected 11", rd_valid); end
    n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL first_read_data: got %h expected 0", rd_data); end
    n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL first_read_busy: got %b expected 00", rd_busy); end
    n_checks++; if (busy_count !== 0) begin n_fail++; $display("FAIL first_read_count: got %0d expected 0", busy_count); end
  endtask

  task automatic test_wb_bypass();
    drive_wb(7, 32'hDEADBEEF);
    tick(); idle();
    drive_read(0, 7);
    tick(); idle();
    n_checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wb_read: got %h expected deadbeef", rd_data[31:0]); end
    drive_wb(7, 32'h12345678); drive_read(1, 7);
    tick(); idle();
    n_checks++; if (rd_data[63:32] !== 32'h12345678) begin n_fail++; $display("FAIL bypass_data: got %h expected 12345678", rd_data[63:32]); end
    n_checks++; if (rd_valid !== 2'b10) begin n_fail++; $display("FAIL bypass_valid: got %b expected 10", rd_valid); end
    n_checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL idle_port_hold: got %h expected deadbeef", rd_data[31:0]); end
    // Both ports on the same address see identical results.
    drive_read(0, 7); drive_read(1, 7);
    tick(); idle();
    n_checks++; if (rd_data !== {32'h12345678, 32'h12345678}) begin n_fail++; $display("FAIL same_addr_data: got %h expected 1234567812345678", rd_data); end
  endtask

  task automatic test_busy();
    drive_reserve(3); tick(); idle();
    drive_reserve(9); tick(); idle();
    n_checks++; if (busy_count !== 2) begin n_fail++; $display("FAIL count_two: got %0d expected 2", busy_count); end
    drive_read(0, 3); tick(); idle();
    n_checks++; if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL busy_x3: got %b expected 1", rd_busy[0]); end
    drive_read(0, 3); drive_wb(3, 32'hA5); tick(); idle();
    n_checks++; if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL wb_clears_hazard: got %b expected 0", rd_busy[0]); end
    n_checks++; if (rd_data[31:0] !== 32'hA5) begin n_fail++; $display("FAIL wb_busy_data: got %h expected a5", rd_data[31:0]); end
    n_checks++; if (busy_count !== 1) begin n_fail++; $display("FAIL count_after_wb: got %0d expected 1", busy_count); end
  endtask

  task automatic test_x0_and_rereserve();
    drive_reserve(0); drive_wb(0, 32'hFF); tick(); idle();
    n_checks++; if (busy_count !== 1) begin n_fail++; $display("FAIL x0_count: got %0d expected 1", busy_count); end
    drive_read(0, 0); drive_read(1, 0); tick(); idle();
    n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL x0_data: got %h expected 0", rd_data); end
    n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL x0_busy: got %b expected 00", rd_busy); end
    drive_reserve(4); tick(); idle();
    n_checks++; if (busy_count !== 2) begin n_fail++; $display("FAIL reserve_x4: got %0d expected 2", busy_count); end
    drive_reserve(4); tick(); idle();
    n_checks++; if (busy_count !== 2) begin n_fail++; $display("FAIL rereserve_x4: got %0d expected 2", busy_count); end
    // A same-cycle reserve is not visible to the read.
    drive_reserve(11); drive_read(0, 11); tick(); idle();
    n_checks++; if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL reserve_not_visible: got %b expected 0", rd_busy[0]); end
    drive_read(0, 11); tick(); idle();
    n_checks++; if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL reserve_visible_later: got %b expected 1", rd_busy[0]); end
    n_checks++; if (busy_count !== 3) begin n_fail++; $display("FAIL count_three: got %0d expected 3", busy_count); end
    // Writeback to a non-busy register leaves the count alone.
    drive_wb(20, 32'h1); tick(); idle();
    n_checks++; if (busy_count !== 3) begin n_fail++; $display("FAIL wb_nonbusy_count: got %0d expected 3", busy_count); end
  endtask

  task automatic test_flush();
    drive_reserve(2); tick(); idle();
    drive_reserve(6); tick(); idle();
    drive_reserve(8); tick(); idle();
    n_checks++; if (busy_count !== 6) begin n_fail++; $display("FAIL pre_flush_count: got %0d expected 6", busy_count); end
    flush = 1'b1; drive_reserve(6); tick(); idle();
    n_checks++; if (busy_count !== 1) begin n_fail++; $display("FAIL flush_count: got %0d expected 1", busy_count); end
    drive_read(0, 6); drive_read(1, 2); tick(); idle();
    n_checks++; if (rd_busy !== 2'b01) begin n_fail++; $display("FAIL flush_x6_x2: got %b expected 01", rd_busy); end
    drive_read(0, 8); tick(); idle();
    n_checks++; if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL flush_x8: got %b expected 0", rd_busy[0]); end
    // Reserve beats a same-cycle writeback to the same register.
    drive_reserve(12); drive_wb(12, 32'h77); tick(); idle();
    n_checks++; if (busy_count !== 2) begin n_fail++; $display("FAIL reserve_over_wb: got %0d expected 2", busy_count); end
  endtask

  task automatic test_async_reset();
    drive_wb(10, 32'h55); tick(); idle();
    drive_reserve(10); tick(); idle();
    drive_read(0, 10); tick();
    n_checks++; if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h55) begin n_fail++; $display("FAIL pre_reset_read: got busy %b data %h expected 1 55", rd_busy[0], rd_data[31:0]); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (rd_valid !== 2'b00 || rd_busy !== 2'b00 || rd_data !== '0) begin n_fail++; $display("FAIL async_reset_outputs: got valid %b busy %b data %h expected 0", rd_valid, rd_busy, rd_data); end
    n_checks++; if (busy_count !== 0) begin n_fail++; $display("FAIL async_reset_count: got %0d expected 0", busy_count); end
    idle();
    #2 rst_n = 1'b1;
    tick();
    n_checks++; if (rd_valid !== 2'b00) begin n_fail++; $display("FAIL release_valid: got %b expected 00", rd_valid); end
    drive_read(0, 10); tick(); idle();
    n_checks++; if (rd_data[31:0] !== '0 || rd_busy[0] !== 1'b0 || rd_valid[0] !== 1'b1) begin n_fail++; $display("FAIL post_reset_x10: got data %h busy %b valid %b expected 0 0 1", rd_data[31:0], rd_busy[0], rd_valid[0]); end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_wb_bypass();
    test_busy();
    test_x0_and_rereserve();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_operand_unit.md
Name: reg_operand_unit

Overview:
- Parametrised successor to the single 5-bit rs1 source-operand channel, covering all source operands of the RISC-V core.
- Combines an N-read/1-write register file with a per-register busy scoreboard, so each read port returns both operand data and a hazard flag.
- Sits between decode (read and reserve requests) and writeback (write port).
- The rs1/rs2 UVCs drive its read-address ports.

Parameters:
- XLEN, 32, data width of each register.
- NUM_REGS, 32, number of architectural registers. Must be a power of two, ≥2.
- NUM_RD_PORTS, 2, number of independent read ports (rs1, rs2, ...).
- ADDR_W, $clog2(NUM_REGS), register address width. Derived localparam, not overridable.

Ports:
- clk  input  1  core clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rd_en_i  input  NUM_RD_PORTS  per-port read request.
- rd_addr_i  input  NUM_RD_PORTS*ADDR_W  packed read addresses; port p at [p*ADDR_W +: ADDR_W].
- rd_data_o  output  NUM_RD_PORTS*XLEN  packed read data; port p at [p*XLEN +: XLEN].
- rd_busy_o  output  NUM_RD_PORTS  source register had an outstanding reservation when sampled.
- rd_valid_o  output  NUM_RD_PORTS  rd_data_o/rd_busy_o for the port are valid this cycle.
- reserve_en_i  input  1  mark a destination register as pending.
- reserve_addr_i  input  ADDR_W  register to reserve.
- wb_en_i  input  1  writeback strobe.
- wb_addr_i  input  ADDR_W  writeback register.
- wb_data_i  input  XLEN  writeback data.
- flush_i  input  1  clear all reservations (pipeline flush).
- busy_count_o  output  $clog2(NUM_REGS+1)  number of set busy bits.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers = 0, all busy bits = 0.
  - rd_data_o = 0, rd_busy_o = 0, rd_valid_o = 0, busy_count_o = 0.
  - Any in-flight read is discarded; nothing is valid in the first cycle after release.
- Read latency is 1 cycle:
  - With rd_en_i[p]=1 at edge k, rd_valid_o[p]=1 during cycle k+1, and data/busy are held until the next read on that port.
  - With rd_en_i[p]=0, rd_valid_o[p] drops to 0; data and busy hold their last values.
- x0 rules:
  - A read of address 0 returns 0 with busy 0.
  - wb and reserve to address 0 are ignored: no storage change, no count change.
- Write-read bypass: if wb_en_i, wb_addr_i==rd_addr_i[p] (nonzero) and rd_en_i[p] all hold in the same cycle, rd_data_o[p] = wb_data_i.
- Busy sampled by a read at cycle k: (busy_q[addr] & ~(wb_en_i & wb_addr_i==addr)).
  - A same-cycle writeback clears the hazard.
  - A same-cycle reserve is NOT visible, because the reader is older in program order.
- Busy-bit update per register, in priority order:
  - reserve to that register → set. Reserve wins over both a same-cycle flush and a same-cycle wb to the same register.
  - else flush_i → clear.
  - else wb to that register → clear.
  - else hold.
- Reserving an already-busy register leaves the bit set and the count unchanged.
- Writeback to a non-busy register writes data and leaves the count unchanged.
- busy_count_o is registered and always equals the popcount of busy bits after the update (0..NUM_REGS-1, since x0 is never busy).
- All ports may target the same address at once; each gets identical results.

Decomposition:
- Shared package reg_operand_pkg:
  - default XLEN/NUM_REGS/NUM_RD_PORTS constants.
  - typedefs reg_addr_t (logic [ADDR_W-1:0]) and reg_data_t (logic [XLEN-1:0]).
  - The rs1/rs2 UVC interfaces import the same reg_addr_t.
- Sub-module reg_busy_scoreboard holds the busy vector, update priority and popcount.
- The top level holds storage, bypass and the per-port read pipeline, built with a generate loop over ports.

Test Plan:
- Reset, then read ports 0/1 at addresses 5/0 → one cycle later valid=2'b11, data=0/0, busy=0/0, busy_count_o=0.
- wb x7=0xDEADBEEF; next cycle read port0 x7 → rd_data_o[0]=0xDEADBEEF one cycle later. In the same cycle, wb x7=0x12345678 with read port1 x7 → port1 returns 0x12345678 (bypass).
- Reserve x3 and x9 → busy_count_o=2. Read x3 → busy=1. Read x3 in the same cycle as wb x3=0xA5 → busy=0, data=0xA5, busy_count_o=1.
- Reserve x0 and wb x0=0xFF → read x0 returns 0, busy=0, count unchanged. Reserve x4 twice → count increments once.
- Reserve x2, x6, x8; then flush_i together with reserve x6 → busy_count_o=1, x6 busy, x2 and x8 not busy.
- Reserve x10, then assert rst_n=0 mid-cycle while a read of x10 is in flight → outputs 0 immediately and asynchronously; after release, a read of x10 returns data 0, busy 0.
